// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: reads instruction words (and an optional
// immediate word) from a synchronous program memory, holds them stable for the
// control unit, and hands execution over with run/done. Includes halt handling,
// modulo program-counter wrap and an execution watchdog.
module instr_fetch_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [15:0]       mem_rdata,
  output logic              run,
  input  logic              done,
  output logic [15:0]       instr_out,
  output logic [15:0]       imm_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              halted,
  output logic              error
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FREQ,
    S_FWAIT,
    S_IREQ,
    S_IWAIT,
    S_ISSUE,
    S_HALT,
    S_ERR
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_rd_en;
  logic              r_run;
  logic [15:0]       r_instr;
  logic [15:0]       r_imm;
  logic              r_busy;
  logic              r_halted;
  logic              r_error;
  logic              r_halt_pend;
  logic [WD_W-1:0]   r_wd;

  logic [ADDR_W-1:0] w_pc_plus1;
  logic [ADDR_W-1:0] w_pc_adv;
  logic [WD_W-1:0]   w_wd_inc;
  logic              w_halt_op;
  logic              w_halt_any;

  // The step past the current instruction depends on whether it carried an immediate.
  assign w_pc_plus1 = r_pc + ADDR_W'(1);
  assign w_pc_adv   = r_instr[12] ? (r_pc + ADDR_W'(2)) : w_pc_plus1;
  assign w_wd_inc   = r_wd + WD_W'(1);
  assign w_halt_op  = (mem_rdata[15:13] == 3'b111);
  assign w_halt_any = r_halt_pend | halt_req;

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_mem_addr  <= '0;
      r_rd_en     <= 1'b0;
      r_run       <= 1'b0;
      r_instr     <= '0;
      r_imm       <= '0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
      r_error     <= 1'b0;
      r_halt_pend <= 1'b0;
      r_wd        <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          // Read strobe is raised on entry so it is high for the whole request cycle.
          if (start) begin
            r_pc       <= '0;
            r_mem_addr <= '0;
            r_rd_en    <= 1'b1;
            r_busy     <= 1'b1;
            r_halted   <= 1'b0;
            r_state    <= S_FREQ;
          end
        end
        S_FREQ: begin
          r_rd_en <= 1'b0;
          r_state <= S_FWAIT;
        end
        S_FWAIT: begin
          r_instr <= mem_rdata;
          if (w_halt_op) begin
            // pc stays on the halt word.
            r_halted <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_HALT;
          end else if (mem_rdata[12]) begin
            r_mem_addr <= w_pc_plus1;
            r_rd_en    <= 1'b1;
            r_state    <= S_IREQ;
          end else begin
            r_wd        <= '0;
            r_halt_pend <= 1'b0;
            r_state     <= S_ISSUE;
          end
        end
        S_IREQ: begin
          r_rd_en <= 1'b0;
          r_state <= S_IWAIT;
        end
        S_IWAIT: begin
          r_imm       <= mem_rdata;
          r_wd        <= '0;
          r_halt_pend <= 1'b0;
          r_state     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (done) begin
            r_run      <= 1'b0;
            r_pc       <= w_pc_adv;
            r_mem_addr <= w_pc_adv;
            if (w_halt_any) begin
              r_halted <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= S_HALT;
            end else begin
              r_rd_en <= 1'b1;
              r_state <= S_FREQ;
            end
          end else begin
            r_halt_pend <= w_halt_any;
            // Only cycles with run already high count against the watchdog.
            if (r_run && (w_wd_inc == WD_W'(TIMEOUT))) begin
              r_run   <= 1'b0;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_ERR;
            end else begin
              if (r_run) r_wd <= w_wd_inc;
              r_run <= 1'b1;
            end
          end
        end
        S_ERR: begin
          r_run   <= 1'b0;
          r_rd_en <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_rd_en = r_rd_en;
  assign run       = r_run;
  assign instr_out = r_instr;
  assign imm_out   = r_imm;
  assign pc_out    = r_pc;
  assign busy      = r_busy;
  assign halted    = r_halted;
  assign error     = r_error;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: a program table is expanded into expected
// fetch addresses and issued instructions, which a monitor pops and compares as
// the sequencer produces them; a second instance with a 2-bit pc covers wrap.
module tb_instr_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, halt_req, done;
  logic [7:0]  mem_addr, pc_out;
  logic        mem_rd_en, run, busy, halted, error;
  logic [15:0] mem_rdata, instr_out, imm_out;

  logic        start1, halt_req1, done1;
  logic [1:0]  mem_addr1, pc_out1;
  logic        mem_rd_en1, run1, busy1, halted1, error1;
  logic [15:0] mem_rdata1, instr_out1, imm_out1;

  logic [15:0] mem0 [256];
  logic [15:0] mem1 [4];

  typedef struct {
    logic [15:0] w;
    logic [15:0] imm;
    int          dly;
    int          halt;
  } ent_t;

  typedef struct {
    int          pc;
    logic [15:0] instr;
    logic [15:0] imm;
    int          dly;
    int          halt;
    int          lat;
    int          exp_len;
  } iss_t;

  ent_t        tbl [11];
  logic [7:0]  addr_q [$];
  iss_t        iss_q [$];
  logic [1:0]  rd1_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          kick = 0;
  logic [15:0] model_imm;
  logic        tb_halt;

  always #5 clk = ~clk;

  instr_fetch_sequencer #(.ADDR_W(8), .TIMEOUT(15)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .run(run), .done(done), .instr_out(instr_out), .imm_out(imm_out),
    .pc_out(pc_out), .busy(busy), .halted(halted), .error(error)
  );

  instr_fetch_sequencer #(.ADDR_W(2), .TIMEOUT(15)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .halt_req(halt_req1),
    .mem_addr(mem_addr1), .mem_rd_en(mem_rd_en1), .mem_rdata(mem_rdata1),
    .run(run1), .done(done1), .instr_out(instr_out1), .imm_out(imm_out1),
    .pc_out(pc_out1), .busy(busy1), .halted(halted1), .error(error1)
  );

  // Synchronous program memories: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en)  mem_rdata  <= mem0[mem_addr];
    if (mem_rd_en1) mem_rdata1 <= mem1[mem_addr1];
  end

  // Edge counter; remembers the edge at which start or done was accepted.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ((start && !busy && !error) || (done && run)) kick <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_run"}, run, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_pc"}, pc_out, 0);
    chk({tag, "_instr"}, instr_out, 0);
    chk({tag, "_imm"}, imm_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset(tag);
    reset_n   = 1'b1;
    model_imm = 16'h0;
  endtask

  // Monitor: checks every memory read and every issued instruction against the
  // expected queues, and plays the control unit (done / halt_req) for u0.
  initial begin : mon
    int         cnt;
    bit         act;
    iss_t       e;
    logic [7:0] a;
    cnt = 0; act = 0; done = 1'b0; halt_req = 1'b0;
    e = '{0, 16'h0, 16'h0, 0, 0, 0, -1};
    forever begin
      @(negedge clk);
      halt_req = tb_halt;
      done     = 1'b0;
      if (mem_rd_en === 1'b1) begin
        if (addr_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rd_unexpected: got read at 0x%0h, expected no read", mem_addr);
        end else begin
          a = addr_q.pop_front();
          chk("rd_addr", mem_addr, a);
        end
      end
      if (run === 1'b1) begin
        if (!act) begin
          act = 1; cnt = 0;
          if (iss_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL issue_unexpected: got run=1 at pc 0x%0h, expected no issue", pc_out);
            e = '{0, 16'h0, 16'h0, 0, 0, 0, -1};
          end else begin
            e = iss_q.pop_front();
            chk("issue_pc", pc_out, e.pc);
            chk("issue_instr", instr_out, e.instr);
            chk("issue_imm", imm_out, e.imm);
            chk("issue_latency", cyc - kick, e.lat);
          end
        end
        cnt++;
        if (e.dly != 0 && cnt == e.dly) begin
          done = 1'b1;
          if (e.halt == 1) halt_req = 1'b1;
        end
        if (e.halt == 2 && cnt == 1) halt_req = 1'b1;
      end else if (act) begin
        act = 0;
        if (e.exp_len >= 0) chk("run_high_cycles", cnt, e.exp_len);
      end
    end
  end

  // Records u1 read addresses for the wrap check.
  initial begin : mon1
    forever begin
      @(negedge clk);
      if (mem_rd_en1 === 1'b1) rd1_q.push_back(mem_addr1);
    end
  end

  // Expand table rows [lo,hi) into memory plus expectations, run to the end state.
  task automatic run_prog(input int lo, input int hi);
    int   a, end_pc;
    bit   to_err, ok;
    iss_t e;
    for (int i = 0; i < 256; i++) mem0[i] = 16'h0;
    a = 0; end_pc = 0; to_err = 0;
    for (int i = lo; i < hi; i++) begin
      mem0[8'(a)] = tbl[i].w;
      addr_q.push_back(8'(a));
      if (tbl[i].w[15:13] == 3'b111) begin
        end_pc = a;
        break;
      end
      if (tbl[i].w[12]) begin
        mem0[8'(a + 1)] = tbl[i].imm;
        addr_q.push_back(8'(a + 1));
        model_imm = tbl[i].imm;
      end
      e.pc = a; e.instr = tbl[i].w; e.imm = model_imm;
      e.dly = tbl[i].dly; e.halt = tbl[i].halt;
      e.lat = tbl[i].w[12] ? 5 : 3;
      e.exp_len = (tbl[i].dly == 0) ? 15 : tbl[i].dly;
      iss_q.push_back(e);
      a = (a + (tbl[i].w[12] ? 2 : 1)) % 256;
      if (tbl[i].dly == 0) begin
        to_err = 1;
        break;
      end
      if (tbl[i].halt != 0) begin
        end_pc = a;
        break;
      end
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = (i == 4 && busy) ? 1'b1 : 1'b0;
      if (halted || error) begin
        ok = 1;
        break;
      end
    end
    start = 1'b0;
    chk("end_state_reached", ok, 1);
    repeat (3) @(negedge clk);
    if (to_err) begin
      chk("end_error", error, 1);
      chk("end_not_halted", halted, 0);
    end else begin
      chk("end_halted", halted, 1);
      chk("end_pc", pc_out, end_pc);
      chk("end_no_error", error, 0);
    end
    chk("end_run", run, 0);
    chk("end_busy", busy, 0);
    chk("end_reads_left", addr_q.size(), 0);
    chk("end_issues_left", iss_q.size(), 0);
    addr_q.delete();
    iss_q.delete();
  endtask

  initial begin : main
    bit   ok;
    iss_t e;
    int   rexp [6];
    rexp = '{0, 1, 2, 3, 0, 1};

    tbl[0]  = '{16'h0203, 16'h0000, 2, 0};
    tbl[1]  = '{16'h5200, 16'h0042, 1, 0};
    tbl[2]  = '{16'h1234, 16'hBEEF, 3, 0};
    tbl[3]  = '{16'h0F0F, 16'h0000, 2, 0};
    tbl[4]  = '{16'hE000, 16'h0000, 0, 0};
    tbl[5]  = '{16'h0203, 16'h0000, 2, 1};
    tbl[6]  = '{16'h0203, 16'h0000, 1, 0};
    tbl[7]  = '{16'h0300, 16'h0000, 2, 0};
    tbl[8]  = '{16'hF000, 16'h0000, 0, 0};
    tbl[9]  = '{16'h1111, 16'h2222, 3, 2};
    tbl[10] = '{16'h0203, 16'h0000, 0, 0};

    reset_n = 1'b0; start = 1'b0; tb_halt = 1'b0; model_imm = 16'h0;
    start1 = 1'b0; halt_req1 = 1'b0; done1 = 1'b0;
    for (int i = 0; i < 4; i++) mem1[i] = 16'h0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    reset_n = 1'b1;

    // halt_req while idle has no effect
    tb_halt = 1'b1;
    repeat (2) @(negedge clk);
    tb_halt = 1'b0;
    @(negedge clk);
    chk("idle_halt_busy", busy, 0);
    chk("idle_halt_halted", halted, 0);
    chk("idle_halt_rd_en", mem_rd_en, 0);

    run_prog(0, 5);
    run_prog(5, 6);
    run_prog(6, 9);
    run_prog(9, 10);
    run_prog(10, 11);

    // ERR is sticky: start is ignored, only reset leaves it
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_sticky_error", error, 1);
    chk("err_sticky_busy", busy, 0);
    chk("err_sticky_run", run, 0);
    do_reset("err_reset");

    // reset while run is high drops run on the reset edge
    mem0[0] = 16'h0203;
    addr_q.push_back(8'h00);
    e = '{0, 16'h0203, 16'h0000, 0, 0, 3, -1};
    iss_q.push_back(e);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (run) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("midreset_run_seen", ok, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset("midreset");
    reset_n = 1'b1;
    addr_q.delete();
    iss_q.delete();

    // 2-bit pc: immediate of the word at 3 comes from address 0, pc wraps 3 -> 1
    mem1[0] = 16'h0055; mem1[1] = 16'h0001; mem1[2] = 16'h0002; mem1[3] = 16'h1200;
    rd1_q.delete();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        if (run1) begin
          ok = 1;
          break;
        end
        @(negedge clk);
      end
      chk("wrap_run_seen", ok, 1);
      chk("wrap_pc", pc_out1, k);
      chk("wrap_instr", instr_out1, mem1[k]);
      if (k == 3) chk("wrap_imm", imm_out1, 16'h0055);
      done1 = 1'b1;
      @(negedge clk);
      done1 = 1'b0;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("wrap_pc_after", pc_out1, 1);
    chk("wrap_rd_count", rd1_q.size(), 6);
    for (int i = 0; i < 6 && i < rd1_q.size(); i++) chk("wrap_rd_addr", rd1_q[i], rexp[i]);
    do_reset("final_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : guard
    #300000;
    $display("FAIL global_timeout: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Fetches 16-bit instruction words from a synchronous program memory, one at a time.
- Presents each word to the control-unit FSM and sequences that FSM with run/done.
- On imm flag (bit 12) = 1, also fetches the next word as a 16-bit immediate for the datapath's immediate bus source.
- Handles halt, wrap-around of the program counter, and an execution watchdog.

Parameters:
- ADDR_W, 8, program memory address width; pc wraps modulo 2^ADDR_W.
- TIMEOUT, 15, maximum cycles run may stay high without done before the error state.

Ports:
- clk  input  1  clock, rising-edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  begin execution at address 0; honoured only in IDLE or HALT.
- halt_req  input  1  stop at the next instruction boundary.
- mem_addr  output  ADDR_W  program memory read address.
- mem_rd_en  output  1  memory read strobe; data returns on mem_rdata one cycle later.
- mem_rdata  input  16  memory read data.
- run  output  1  to control unit; low forces it to T0, high lets it execute.
- done  input  1  from control unit; instruction complete.
- instr_out  output  16  current instruction word; drives the control-unit IR source.
- imm_out  output  16  current immediate word.
- pc_out  output  ADDR_W  address of the current instruction.
- busy  output  1  high in any state except IDLE, HALT and ERR.
- halted  output  1  high in HALT.
- error  output  1  high in ERR.

Behaviour:
- All outputs are registered.
- Reset, sampled on a clk edge with reset_n=0, takes priority over everything:
  - state=IDLE.
  - run=0, mem_rd_en=0, mem_addr=0, pc_out=0, instr_out=0, imm_out=0, busy=0, halted=0, error=0, watchdog=0.
  - Reset mid-instruction drops run on the same edge.
- States and transitions:
  - IDLE: start=1 -> pc=0, go to F_REQ.
  - F_REQ: mem_rd_en=1, mem_addr=pc. Go to F_WAIT.
  - F_WAIT: mem_rd_en=0. Latch mem_rdata into instr_out. Then:
    - opcode (bits 15:13) = 3'b111 -> HALT; pc is unchanged and points at the halt word.
    - else bit 12 = 1 -> I_REQ.
    - else -> ISSUE.
  - I_REQ: mem_rd_en=1, mem_addr=pc+1 (wraps). Go to I_WAIT.
  - I_WAIT: latch mem_rdata into imm_out. Go to ISSUE.
  - ISSUE: run=1. On each cycle with done=1:
    - run=0 on the next edge.
    - pc += 1 for a plain instruction, pc += 2 for one with an immediate (both mod 2^ADDR_W).
    - Next state: halt_req seen at any time since entering ISSUE -> HALT; otherwise F_REQ.
    - Otherwise the watchdog increments. When it reaches TIMEOUT -> ERR.
  - HALT: run=0, halted=1. start=1 -> pc=0, halted=0, go to F_REQ.
  - ERR: run=0, error=1, busy=0. Exit only by reset.
- run is low in every state except ISSUE. This guarantees at least 3 low cycles between instructions, so the control unit always re-enters T0.
- instr_out and imm_out are stable for the whole time run=1. imm_out keeps its old value for instructions without an immediate.
- Latency:
  - Plain instruction: first run-high edge comes 3 cycles after the start edge.
  - Instruction with immediate: 5 cycles.
  - Turnaround from done to the next run-high: 3 cycles plain, 5 with immediate.
- halt_req and done in the same cycle: the instruction completes, pc advances, then HALT.
- halt_req in IDLE: ignored. start while busy: ignored.
- done while not in ISSUE: ignored.
- The watchdog clears on entry to ISSUE.

Test Plan:
- mem[0]=16'h0203 (mv, imm flag 0), done pulsed 1 cycle after run rises -> instr_out=0203, run high exactly 2 cycles, pc_out goes 0 -> 1, next fetch at mem_addr=1.
- mem[0]=16'h5200 (add, imm flag 1), mem[1]=16'h0042 -> mem_addr sequence 0, 1; imm_out=0042 before run rises; next fetch at address 2.
- ADDR_W=2; mem[3]=16'h1200 (imm flag 1), mem[0]=16'h0055 -> immediate read from address 0; pc wraps 3 -> 1.
- mem[2]=16'hE000 -> after 2 instructions: halted=1, run=0, pc_out=2. Then start=1 -> fetch from address 0.
- halt_req asserted the same cycle as done on instruction 0 -> HALT with pc_out=1; no further mem_rd_en.
- done held 0 -> after 15 run-high cycles: error=1, run=0. Stays in ERR until reset_n=0, which clears all outputs.
